// File: rtl/cov_matrix_pkg.sv
// Shared types and helpers for the covariance-matrix accumulator: input modes,
// FSM states, lower-triangle element indexing and status bit positions.
package cov_matrix_pkg;

    typedef enum logic [1:0] {
        SEL_DIRECT = 2'd0,
        SEL_SIGN   = 2'd1,
        SEL_BCAST  = 2'd2,
        SEL_ZERO   = 2'd3
    } sel_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ACC,
        ST_FLUSH,
        ST_DUMP
    } state_e;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_READY   = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_RUN_LSB = 8;
    localparam int STAT_RUN_W   = 8;

    // Row-major lower triangle, r >= c.
    function automatic int tri_idx(input int r, input int c);
        return r * (r + 1) / 2 + c;
    endfunction

endpackage

// File: rtl/cov_tap_line.sv
// Input mode mux followed by an NT-deep delay line; x_o holds tap k of channel c
// at element k*NCH+c, with tap 0 being the current (undelayed) mapped sample.
module cov_tap_line
    import cov_matrix_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int NT    = 2,
    parameter int WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      ena_i,
    input  logic [1:0]                sel_i,
    input  logic [NCH*WIDTH-1:0]      y_i,
    output logic [NCH*NT*WIDTH-1:0]   x_o
);

    logic [NCH*WIDTH-1:0] mapped_w;

    always_comb begin
        mapped_w = '0;
        for (int c = 0; c < NCH; c++) begin
            case (sel_e'(sel_i))
                SEL_DIRECT: mapped_w[c*WIDTH +: WIDTH] = y_i[c*WIDTH +: WIDTH];
                SEL_SIGN:   mapped_w[c*WIDTH +: WIDTH] = y_i[(c+1)*WIDTH-1] ? '1 : WIDTH'(1);
                SEL_BCAST:  mapped_w[c*WIDTH +: WIDTH] = y_i[WIDTH-1:0];
                default:    mapped_w[c*WIDTH +: WIDTH] = '0;
            endcase
        end
    end

    if (NT > 1) begin : g_dly
        logic [(NT-1)*NCH*WIDTH-1:0] dly_q;

        // The lower taps of x_o are exactly the next contents of the line.
        always_ff @(posedge clk_i) begin
            if (reset_i)
                dly_q <= '0;
            else if (ena_i)
                dly_q <= x_o[(NT-1)*NCH*WIDTH-1:0];
        end

        assign x_o = {dly_q, mapped_w};
    end else begin : g_nodly
        assign x_o = mapped_w;
    end

endmodule

// File: rtl/cov_matrix_acc.sv
// Covariance-matrix accumulator: sums the lower triangle of x*x^T over a run of
// enabled samples with saturation, then publishes it to a readout bank.
//
// state    | meaning
// ST_IDLE  | waiting for a start rising edge
// ST_FILL  | priming the delay line before accumulation
// ST_ACC   | registering products of each enabled sample
// ST_FLUSH | last product lands in the accumulators
// ST_DUMP  | accumulators copied to bank, ready set, run counted
module cov_matrix_acc
    import cov_matrix_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int NT      = 2,
    parameter int WIDTH   = 8,
    parameter int ACC_W   = 26,
    parameter int NSTAT_W = 12
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  ena_i,
    input  logic [NCH*WIDTH-1:0]  y_i,
    input  logic [1:0]            sel_i,
    input  logic [NSTAT_W-1:0]    nstat_i,
    input  logic                  start_i,
    input  logic                  cont_i,
    input  logic [31:0]           rd_addr_i,
    output logic [31:0]           rd_data_o,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic [31:0]           status_o
);

    localparam int MSIZE  = NCH * NT;
    localparam int ELEM   = MSIZE * (MSIZE + 1) / 2;
    localparam int FILL_W = $clog2(NT + 1);
    localparam logic signed [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SUM_MIN = -SUM_MAX;

    if (ACC_W < 2*WIDTH + 1 || ACC_W > 32) begin : g_bad_acc_w
        $error("cov_matrix_acc: ACC_W out of range");
    end

    state_e                    state_q;
    logic                      start_q, prod_vld_q, ready_q, ovf_q, bank_ovf_q;
    logic [7:0]                run_cnt_q;
    logic [NSTAT_W-1:0]        samp_cnt_q, nstat_eff;
    logic [FILL_W-1:0]         fill_cnt_q;
    logic [ELEM*ACC_W-1:0]     acc_w, bank_q;
    logic [ELEM-1:0]           sat_w;
    logic [MSIZE*WIDTH-1:0]    x_w;
    logic [31:0]               rd_data_q, status_w;
    logic signed [ACC_W-1:0]   rd_elem;
    logic                      start_edge, run_go, prod_en;

    assign start_edge = start_i & ~start_q;
    assign run_go     = (state_q == ST_IDLE && start_edge) || (state_q == ST_DUMP && cont_i);
    assign prod_en    = (state_q == ST_ACC) && ena_i;
    assign nstat_eff  = (nstat_i == '0) ? NSTAT_W'(1) : nstat_i;

    cov_tap_line #(.NCH(NCH), .NT(NT), .WIDTH(WIDTH)) u_tap (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .ena_i   (ena_i),
        .sel_i   (sel_i),
        .y_i     (y_i),
        .x_o     (x_w)
    );

    for (genvar r = 0; r < MSIZE; r++) begin : g_row
        for (genvar c = 0; c <= r; c++) begin : g_col
            localparam int IDX = tri_idx(r, c);
            logic signed [WIDTH-1:0]   xr_w, xc_w;
            logic signed [2*WIDTH-1:0] prod_q;
            logic signed [ACC_W-1:0]   acc_q, acc_d;
            logic signed [ACC_W:0]     sum_w;

            assign xr_w  = x_w[r*WIDTH +: WIDTH];
            assign xc_w  = x_w[c*WIDTH +: WIDTH];
            assign sum_w = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_q);
            assign sat_w[IDX] = (sum_w > SUM_MAX) || (sum_w < SUM_MIN);
            assign acc_d = (sum_w > SUM_MAX) ? SUM_MAX[ACC_W-1:0] :
                           (sum_w < SUM_MIN) ? SUM_MIN[ACC_W-1:0] : sum_w[ACC_W-1:0];
            assign acc_w[IDX*ACC_W +: ACC_W] = acc_q;

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    prod_q <= '0;
                    acc_q  <= '0;
                end else begin
                    if (prod_en)
                        prod_q <= (2*WIDTH)'(xr_w) * (2*WIDTH)'(xc_w);
                    if (run_go)
                        acc_q <= '0;
                    else if (prod_vld_q)
                        acc_q <= acc_d;
                end
            end
        end
    end

    always_comb begin
        rd_elem = '0;
        for (int i = 0; i < ELEM; i++)
            if (rd_addr_i == 32'(i))
                rd_elem = bank_q[i*ACC_W +: ACC_W];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            prod_vld_q <= 1'b0;
            ready_q    <= 1'b0;
            ovf_q      <= 1'b0;
            bank_ovf_q <= 1'b0;
            run_cnt_q  <= '0;
            samp_cnt_q <= '0;
            fill_cnt_q <= '0;
            bank_q     <= '0;
            rd_data_q  <= '0;
        end else begin
            start_q    <= start_i;
            prod_vld_q <= prod_en;
            rd_data_q  <= 32'(rd_elem);
            if (run_go)
                ovf_q <= 1'b0;
            else if (prod_vld_q && |sat_w)
                ovf_q <= 1'b1;
            case (state_q)
                ST_IDLE: if (start_edge) begin
                    ready_q    <= 1'b0;
                    bank_ovf_q <= 1'b0;
                    samp_cnt_q <= nstat_eff;
                    fill_cnt_q <= FILL_W'(NT - 1);
                    state_q    <= (NT == 1) ? ST_ACC : ST_FILL;
                end
                ST_FILL: if (ena_i) begin
                    if (fill_cnt_q == FILL_W'(1))
                        state_q <= ST_ACC;
                    else
                        fill_cnt_q <= fill_cnt_q - FILL_W'(1);
                end
                ST_ACC: if (ena_i) begin
                    if (samp_cnt_q == NSTAT_W'(1))
                        state_q <= ST_FLUSH;
                    else
                        samp_cnt_q <= samp_cnt_q - NSTAT_W'(1);
                end
                ST_FLUSH: state_q <= ST_DUMP;
                ST_DUMP: begin
                    bank_q     <= acc_w;
                    bank_ovf_q <= ovf_q;
                    ready_q    <= 1'b1;
                    run_cnt_q  <= run_cnt_q + 8'd1;
                    // Delay line is still primed, so one enabled sample ends FILL.
                    if (cont_i) begin
                        samp_cnt_q <= nstat_eff;
                        fill_cnt_q <= FILL_W'(1);
                        state_q    <= (NT == 1) ? ST_ACC : ST_FILL;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        status_w = '0;
        status_w[STAT_BUSY]  = busy_o;
        status_w[STAT_READY] = ready_q;
        status_w[STAT_OVF]   = bank_ovf_q;
        status_w[STAT_RUN_LSB +: STAT_RUN_W] = run_cnt_q;
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign ready_o   = ready_q;
    assign rd_data_o = rd_data_q;
    assign status_o  = status_w;

endmodule

// File: tb/tb_cov_matrix_acc.sv
// Directed bench for cov_matrix_acc: three configurations sharing control
// inputs, each scenario with hand-computed expected bank contents.
module tb_cov_matrix_acc;

    logic        clk, reset, ena, cont;
    logic [1:0]  sel;
    logic [11:0] nstat;
    logic [31:0] rd_addr;
    logic        start_a, start_b, start_c;
    logic [15:0] y_a;
    logic [7:0]  y_b, y_c;
    logic [31:0] rd_data_a, rd_data_b, rd_data_c;
    logic [31:0] status_a, status_b, status_c;
    logic        ready_a, ready_b, ready_c, busy_a, busy_b, busy_c;
    int          total, bad;

    cov_matrix_acc #(.NCH(2), .NT(1), .WIDTH(8), .ACC_W(26), .NSTAT_W(12)) u_a (
        .clk_i(clk), .reset_i(reset), .ena_i(ena), .y_i(y_a), .sel_i(sel),
        .nstat_i(nstat), .start_i(start_a), .cont_i(cont), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_a), .ready_o(ready_a), .busy_o(busy_a), .status_o(status_a));

    cov_matrix_acc #(.NCH(1), .NT(2), .WIDTH(8), .ACC_W(26), .NSTAT_W(12)) u_b (
        .clk_i(clk), .reset_i(reset), .ena_i(ena), .y_i(y_b), .sel_i(sel),
        .nstat_i(nstat), .start_i(start_b), .cont_i(cont), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_b), .ready_o(ready_b), .busy_o(busy_b), .status_o(status_b));

    cov_matrix_acc #(.NCH(1), .NT(1), .WIDTH(8), .ACC_W(17), .NSTAT_W(12)) u_c (
        .clk_i(clk), .reset_i(reset), .ena_i(ena), .y_i(y_c), .sel_i(sel),
        .nstat_i(nstat), .start_i(start_c), .cont_i(cont), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_c), .ready_o(ready_c), .busy_o(busy_c), .status_o(status_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rdat_of(input int inst);
        case (inst)
            0:       return rd_data_a;
            1:       return rd_data_b;
            default: return rd_data_c;
        endcase
    endfunction

    function automatic logic busy_of(input int inst);
        case (inst)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; ena = 1'b0; cont = 1'b0; sel = 2'd0; nstat = 12'd0; rd_addr = 32'd0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic pulse_start(input int inst);
        case (inst)
            0:       start_a = 1'b1;
            1:       start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        step(1);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    task automatic feed(input int n);
        ena = 1'b1;
        step(n);
        ena = 1'b0;
    endtask

    task automatic wait_idle(input int inst, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy_of(inst)) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic rd(input int inst, input logic [31:0] a, output logic [31:0] d);
        rd_addr = a;
        step(1);
        d = rdat_of(inst);
    endtask

    task automatic test_reset();
        reset = 1'b1; ena = 1'b0; cont = 1'b0; sel = 2'd0; nstat = 12'd0; rd_addr = 32'd0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        y_a = 16'd0; y_b = 8'd0; y_c = 8'd0;
        step(3);
        reset = 1'b0;
        step(1);
        total++; if (status_a !== 32'd0) begin bad++; $display("FAIL reset_status_a got=%h exp=%h", status_a, 32'd0); end
        total++; if (status_b !== 32'd0) begin bad++; $display("FAIL reset_status_b got=%h exp=%h", status_b, 32'd0); end
        total++; if (status_c !== 32'd0) begin bad++; $display("FAIL reset_status_c got=%h exp=%h", status_c, 32'd0); end
        total++; if (rd_data_a !== 32'd0) begin bad++; $display("FAIL reset_rd_data_a got=%h exp=%h", rd_data_a, 32'd0); end
        total++; if ({ready_a, busy_a} !== 2'b00) begin bad++; $display("FAIL reset_ready_busy_a got=%b exp=%b", {ready_a, busy_a}, 2'b00); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        bit ok;
        do_reset();
        nstat = 12'd4; y_a = {8'hFE, 8'h03};
        pulse_start(0);
        feed(4);
        total++; if ({ready_a, busy_a} !== 2'b01) begin bad++; $display("FAIL basic_lat1 got=%b exp=%b", {ready_a, busy_a}, 2'b01); end
        step(1);
        total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL basic_lat2 got=%b exp=%b", ready_a, 1'b0); end
        step(1);
        total++; if ({ready_a, busy_a} !== 2'b10) begin bad++; $display("FAIL basic_lat3 got=%b exp=%b", {ready_a, busy_a}, 2'b10); end
        wait_idle(0, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=busy exp=idle"); end
        total++; if (status_a !== 32'h0000_0102) begin bad++; $display("FAIL basic_status got=%h exp=%h", status_a, 32'h0000_0102); end
        rd(0, 32'd0, d);
        total++; if (d !== 32'd36) begin bad++; $display("FAIL basic_idx0 got=%h exp=%h", d, 32'd36); end
        rd(0, 32'd1, d);
        total++; if (d !== 32'hFFFF_FFE8) begin bad++; $display("FAIL basic_idx1 got=%h exp=%h", d, 32'hFFFF_FFE8); end
        rd(0, 32'd2, d);
        total++; if (d !== 32'd16) begin bad++; $display("FAIL basic_idx2 got=%h exp=%h", d, 32'd16); end
        rd(0, 32'd3, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL basic_oob got=%h exp=%h", d, 32'd0); end
        rd(0, 32'hFFFF_FFFF, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL basic_oob_max got=%h exp=%h", d, 32'd0); end
    endtask

    task automatic test_fill();
        logic [31:0] d;
        bit ok;
        do_reset();
        nstat = 12'd3; y_b = 8'd0;
        pulse_start(1);
        total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL fill_busy got=%b exp=%b", busy_b, 1'b1); end
        for (int v = 1; v <= 4; v++) begin
            y_b = 8'(v);
            ena = 1'b1;
            step(1);
        end
        ena = 1'b0;
        wait_idle(1, ok);
        total++; if (!ok) begin bad++; $display("FAIL fill_timeout got=busy exp=idle"); end
        rd(1, 32'd0, d);
        total++; if (d !== 32'd29) begin bad++; $display("FAIL fill_idx0 got=%h exp=%h", d, 32'd29); end
        rd(1, 32'd1, d);
        total++; if (d !== 32'd20) begin bad++; $display("FAIL fill_idx1 got=%h exp=%h", d, 32'd20); end
        rd(1, 32'd2, d);
        total++; if (d !== 32'd14) begin bad++; $display("FAIL fill_idx2 got=%h exp=%h", d, 32'd14); end
    endtask

    task automatic test_sel();
        logic [31:0] d;
        bit ok;
        do_reset();
        sel = 2'd1; nstat = 12'd10; y_a = {8'd5, 8'h9C};
        pulse_start(0);
        feed(10);
        wait_idle(0, ok);
        total++; if (!ok) begin bad++; $display("FAIL sign_timeout got=busy exp=idle"); end
        rd(0, 32'd0, d);
        total++; if (d !== 32'd10) begin bad++; $display("FAIL sign_idx0 got=%h exp=%h", d, 32'd10); end
        rd(0, 32'd1, d);
        total++; if (d !== 32'hFFFF_FFF6) begin bad++; $display("FAIL sign_idx1 got=%h exp=%h", d, 32'hFFFF_FFF6); end
        rd(0, 32'd2, d);
        total++; if (d !== 32'd10) begin bad++; $display("FAIL sign_idx2 got=%h exp=%h", d, 32'd10); end

        sel = 2'd3; nstat = 12'd3;
        pulse_start(0);
        total++; if ({ready_a, busy_a} !== 2'b01) begin bad++; $display("FAIL start_clears_ready got=%b exp=%b", {ready_a, busy_a}, 2'b01); end
        feed(3);
        wait_idle(0, ok);
        total++; if (!ok) begin bad++; $display("FAIL zero_timeout got=busy exp=idle"); end
        rd(0, 32'd0, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL zero_idx0 got=%h exp=%h", d, 32'd0); end
        rd(0, 32'd1, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL zero_idx1 got=%h exp=%h", d, 32'd0); end

        sel = 2'd2; nstat = 12'd2; y_a = {8'hFD, 8'h07};
        pulse_start(0);
        feed(2);
        wait_idle(0, ok);
        total++; if (!ok) begin bad++; $display("FAIL bcast_timeout got=busy exp=idle"); end
        rd(0, 32'd1, d);
        total++; if (d !== 32'd98) begin bad++; $display("FAIL bcast_idx1 got=%h exp=%h", d, 32'd98); end
        rd(0, 32'd2, d);
        total++; if (d !== 32'd98) begin bad++; $display("FAIL bcast_idx2 got=%h exp=%h", d, 32'd98); end

        sel = 2'd0; nstat = 12'd0; y_a = {8'hFE, 8'h03};
        pulse_start(0);
        feed(1);
        wait_idle(0, ok);
        total++; if (!ok) begin bad++; $display("FAIL nstat0_timeout got=busy exp=idle"); end
        rd(0, 32'd1, d);
        total++; if (d !== 32'hFFFF_FFFA) begin bad++; $display("FAIL nstat0_idx1 got=%h exp=%h", d, 32'hFFFF_FFFA); end
        total++; if (status_a[15:8] !== 8'd4) begin bad++; $display("FAIL sel_run_cnt got=%0d exp=%0d", status_a[15:8], 4); end
    endtask

    task automatic test_busy_start();
        logic [31:0] d;
        bit ok;
        do_reset();
        nstat = 12'd4; y_a = {8'd1, 8'd2};
        pulse_start(0);
        ena = 1'b1;
        step(2);
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        step(1);
        ena = 1'b0;
        wait_idle(0, ok);
        total++; if (!ok) begin bad++; $display("FAIL busystart_timeout got=busy exp=idle"); end
        rd(0, 32'd0, d);
        total++; if (d !== 32'd16) begin bad++; $display("FAIL busystart_idx0 got=%h exp=%h", d, 32'd16); end
        rd(0, 32'd1, d);
        total++; if (d !== 32'd8) begin bad++; $display("FAIL busystart_idx1 got=%h exp=%h", d, 32'd8); end
        total++; if (status_a !== 32'h0000_0102) begin bad++; $display("FAIL busystart_status got=%h exp=%h", status_a, 32'h0000_0102); end
    endtask

    task automatic test_saturate();
        logic [31:0] d;
        bit ok;
        do_reset();
        nstat = 12'd8; y_c = 8'h80;
        pulse_start(2);
        feed(8);
        wait_idle(2, ok);
        total++; if (!ok) begin bad++; $display("FAIL sat_timeout got=busy exp=idle"); end
        rd(2, 32'd0, d);
        total++; if (d !== 32'h0000_FFFF) begin bad++; $display("FAIL sat_idx0 got=%h exp=%h", d, 32'h0000_FFFF); end
        total++; if (status_c[2] !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b exp=%b", status_c[2], 1'b1); end
        y_c = 8'd1;
        pulse_start(2);
        total++; if (status_c[2] !== 1'b0) begin bad++; $display("FAIL sat_ovf_clear got=%b exp=%b", status_c[2], 1'b0); end
        feed(8);
        wait_idle(2, ok);
        total++; if (!ok) begin bad++; $display("FAIL sat2_timeout got=busy exp=idle"); end
        rd(2, 32'd0, d);
        total++; if (d !== 32'd8) begin bad++; $display("FAIL sat2_idx0 got=%h exp=%h", d, 32'd8); end
        total++; if (status_c !== 32'h0000_0202) begin bad++; $display("FAIL sat2_status got=%h exp=%h", status_c, 32'h0000_0202); end
    endtask

    task automatic test_cont();
        int  phase, wait1;
        bit  done, ok;
        do_reset();
        nstat = 12'd2; cont = 1'b1; y_a = {8'hFE, 8'h03}; rd_addr = 32'd0;
        pulse_start(0);
        phase = 0; wait1 = 0; done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            ena = ~ena;
            step(1);
            if (phase == 0) begin
                if (status_a[15:8] == 8'd1) begin
                    y_a = 16'h0101;
                    phase = 1;
                    wait1 = 1;
                end
            end else begin
                total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL cont_ready_held got=%b exp=%b", ready_a, 1'b1); end
                wait1++;
                if (status_a[15:8] == 8'd2)
                    done = 1'b1;
                else if (wait1 >= 3) begin
                    total++; if (rd_data_a !== 32'd18) begin bad++; $display("FAIL cont_read_prev got=%h exp=%h", rd_data_a, 32'd18); end
                end
            end
        end
        ena = 1'b0;
        total++; if (!done) begin bad++; $display("FAIL cont_timeout got=runs<2 exp=runs2"); end
        step(1);
        total++; if (rd_data_a !== 32'd2) begin bad++; $display("FAIL cont_run2_idx0 got=%h exp=%h", rd_data_a, 32'd2); end
        cont = 1'b0;
        ena = 1'b1;
        wait_idle(0, ok);
        ena = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL cont_stop_timeout got=busy exp=idle"); end
        total++; if (status_a !== 32'h0000_0302) begin bad++; $display("FAIL cont_stop_status got=%h exp=%h", status_a, 32'h0000_0302); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bit ok;
        do_reset();
        nstat = 12'd4; y_a = {8'hFE, 8'h03};
        pulse_start(0);
        feed(4);
        wait_idle(0, ok);
        rd(0, 32'd0, d);
        total++; if (d !== 32'd36) begin bad++; $display("FAIL rmid_pre got=%h exp=%h", d, 32'd36); end
        pulse_start(0);
        ena = 1'b1;
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        ena = 1'b0;
        total++; if ({ready_a, busy_a} !== 2'b00) begin bad++; $display("FAIL rmid_flags got=%b exp=%b", {ready_a, busy_a}, 2'b00); end
        total++; if (rd_data_a !== 32'd0) begin bad++; $display("FAIL rmid_rd_data got=%h exp=%h", rd_data_a, 32'd0); end
        step(1);
        total++; if (rd_data_a !== 32'd0) begin bad++; $display("FAIL rmid_bank got=%h exp=%h", rd_data_a, 32'd0); end
        nstat = 12'd1;
        pulse_start(0);
        feed(1);
        wait_idle(0, ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_timeout got=busy exp=idle"); end
        rd(0, 32'd0, d);
        total++; if (d !== 32'd9) begin bad++; $display("FAIL rmid_idx0 got=%h exp=%h", d, 32'd9); end
        total++; if (status_a !== 32'h0000_0102) begin bad++; $display("FAIL rmid_status got=%h exp=%h", status_a, 32'h0000_0102); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_fill();
        test_sel();
        test_busy_start();
        test_saturate();
        test_cont();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
